char_column_sequencer: RTL

- Sequences the ASCII-to-character encoder and character ROM to stream a stored text message as 8-bit font columns to a downstream display writer.
- Holds a small message buffer that is written by the host.
- On start, presents each character to the encoder, waits for the ROM, then steps the column key 0..5 (5 = blank spacer column).
- Emits each column over a valid/ready handshake.

---
 rtl/char_seq_pkg.sv | 23 ++
 rtl/char_msg_buffer.sv | 25 ++
 rtl/char_column_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/char_seq_pkg.sv
// Shared definitions for the character column sequencer: FSM encoding,
// column geometry and the idle character value.
package char_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_ROM = 3'd2,
        S_LOAD     = 3'd3,
        S_EMIT     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int         COLS_PER_CHAR = 6;
    localparam logic [2:0] SPACER_KEY    = 3'b101;
    localparam logic [7:0] BLANK_CHAR    = 8'h20;

    // A requested message length never exceeds the buffer depth.
    function automatic int clamp_len(input int len, input int depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/char_msg_buffer.sv
// Host-written message store: DEPTH x 8, synchronous write, asynchronous read.
// Contents are deliberately not reset so a message survives a sequencer reset.
module char_msg_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/char_column_sequencer.sv
// Streams a buffered text message as 8-bit font columns (6 per character,
// the last being the blank spacer). Build option CHAR_SEQ_LOOP_EN repeats
// the message forever instead of finishing with a done pulse.
//
// Column handshake: col_data/col_last are valid while col_valid is high and
// are held stable until the cycle in which col_valid && col_ready; that
// cycle transfers the column. A column is never withdrawn except by abort/rst.
module char_column_sequencer
    import char_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int ROM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   msg_len,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [7:0]    char_out,
    output logic [2:0]    key_out,
    input  logic [7:0]    enc_col,
    output logic [7:0]    col_data,
    output logic          col_valid,
    input  logic          col_ready,
    output logic          col_last,
    output logic [2:0]    dbg_state
);

    localparam int         LW       = AW + 1;
    localparam logic [2:0] CNT_INIT = 3'(ROM_LAT);

`ifdef CHAR_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [LW-1:0] len_q;
    logic [2:0]    cnt_q;
    logic [LW-1:0] start_len;
    logic [7:0]    buf_rd_data;
    logic          buf_we;
    logic          last_char;
    logic          handshake;

    assign start_len = LW'(clamp_len(int'(msg_len), DEPTH));
    assign last_char = ({1'b0, idx_q} == (len_q - 1'b1));
    assign handshake = col_valid && col_ready;
    assign buf_we    = wr_en && (state_q == S_IDLE);

    char_msg_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (start_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:    state_d = (ROM_LAT == 0) ? S_LOAD : S_WAIT_ROM;
            S_WAIT_ROM: if (cnt_q <= 3'd1) state_d = S_LOAD;
            S_LOAD:     state_d = S_EMIT;
            S_EMIT: begin
                if (handshake) begin
                    if (key_out < SPACER_KEY) begin
                        state_d = S_LOAD;
                    end else if (!last_char || LOOP_EN) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Datapath registers; abort drops any in-flight column.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            char_out  <= BLANK_CHAR;
            key_out   <= '0;
            col_data  <= '0;
            col_valid <= 1'b0;
            col_last  <= 1'b0;
        end else if (abort) begin
            col_valid <= 1'b0;
            col_last  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q <= start_len;
                        idx_q <= '0;
                    end
                end
                S_FETCH: begin
                    char_out <= buf_rd_data;
                    key_out  <= '0;
                    cnt_q    <= CNT_INIT;
                end
                S_WAIT_ROM: cnt_q <= cnt_q - 3'd1;
                S_LOAD: begin
                    col_data  <= enc_col;
                    col_valid <= 1'b1;
                    col_last  <= (key_out == SPACER_KEY) && last_char;
                end
                S_EMIT: begin
                    if (handshake) begin
                        col_valid <= 1'b0;
                        col_last  <= 1'b0;
                        if (key_out < SPACER_KEY) begin
                            key_out <= key_out + 3'd1;
                        end else if (!last_char) begin
                            idx_q <= idx_q + 1'b1;
                        end else if (LOOP_EN) begin
                            idx_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

endmodule
